mem_access: RTL and testbench

//  MEM-stage load/store unit. Consumes the EX/MEM register outputs (wd, wreg, wdata, aluop, mem_addr, reg2).

---
 rtl/mem_access_pkg.sv | 42 ++++
 rtl/mem_access_lane_align.sv | 69 ++++++
 rtl/mem_access.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// ============================================================================
// mem_access_pkg : FSM states, opcodes and helpers shared by the MEM stage
// Revision       : 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_BUS  = 2'b01,
    MEM_HOLD = 2'b10
  } mem_state_e;

  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

  function automatic logic is_store_op(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: return 1'b1;
      default:                                                 return is_store_op(op);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_lane_align.sv
// ============================================================================
// mem_access_lane_align : big-endian byte-lane select, store replication and
//                         load extraction/extension for one memory access
// Revision              : 1.0
// ============================================================================
`default_nettype none

module mem_access_lane_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[31:24];
    case (addr_lo)
      2'b01:   byte_v = rdata[23:16];
      2'b10:   byte_v = rdata[15:8];
      2'b11:   byte_v = rdata[7:0];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
  end

  // Byte address 0 maps to the most significant lane.
  always_comb begin
    sel       = 4'b0000;
    wdata     = 32'h0;
    load_data = 32'h0;
    misalign  = 1'b0;
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        sel       = 4'b1000 >> addr_lo;
        wdata     = {4{reg2[7:0]}};
        load_data = (aluop == EXE_LB_OP) ? {{24{byte_v[7]}}, byte_v}
                                         : {24'h0, byte_v};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        misalign  = addr_lo[0];
        sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata     = {2{reg2[15:0]}};
        load_data = (aluop == EXE_LH_OP) ? {{16{half_v[15]}}, half_v}
                                         : {16'h0, half_v};
      end
      EXE_LW_OP, EXE_SW_OP: begin
        misalign  = |addr_lo;
        sel       = 4'b1111;
        wdata     = reg2;
        load_data = rdata;
      end
      default: begin
        sel = 4'b0000;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// mem_access : MEM-stage load/store unit with a single-outstanding req/ack
//              data bus, pipeline stall request and write-back hold buffer
// Revision   : 1.0
// ============================================================================
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  output logic        bus_we_o,
  output logic        bus_stb_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        err_align_o,
  output logic        err_bus_o
);

  localparam int              CNT_W      = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic            TIMEOUT_EN = (BUS_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BUS_TIMEOUT - 1);

  mem_state_e       state;
  mem_state_e       next_state;
  logic             start;
  logic             killed;
  logic             timeout;

  logic [4:0]       op_wd;
  logic [7:0]       op_aluop;
  logic [1:0]       op_off;
  logic             op_flushed;
  logic [CNT_W-1:0] cnt;

  logic [4:0]       buf_wd;
  logic             buf_wreg;
  logic [31:0]      buf_wdata;

  logic [7:0]       la_aluop;
  logic [1:0]       la_off;
  logic [3:0]       la_sel;
  logic [31:0]      la_wdata;
  logic [31:0]      la_load;
  logic             la_misalign;
  logic             in_is_mem;
  logic             in_is_store;

  logic             unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

  // Lane logic sees the live op while idle and the latched op during the transfer.
  assign la_aluop    = (state == MEM_IDLE) ? aluop_i : op_aluop;
  assign la_off      = (state == MEM_IDLE) ? mem_addr_i[1:0] : op_off;
  assign in_is_mem   = is_mem_op(aluop_i);
  assign in_is_store = is_store_op(aluop_i);

  mem_access_lane_align u_lane (
    .aluop     (la_aluop),
    .addr_lo   (la_off),
    .reg2      (reg2_i),
    .rdata     (bus_rdata_i),
    .sel       (la_sel),
    .wdata     (la_wdata),
    .load_data (la_load),
    .misalign  (la_misalign)
  );

  assign killed  = flush_i | op_flushed;
  assign timeout = TIMEOUT_EN && (state == MEM_BUS) && !bus_ack_i && (cnt == CNT_LAST);

  always_comb begin
    next_state  = state;
    start       = 1'b0;
    wd_o        = wd_i;
    wreg_o      = wreg_i & ~flush_i;
    wdata_o     = wdata_i;
    stallreq_o  = 1'b0;
    err_align_o = 1'b0;
    err_bus_o   = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (in_is_mem) begin
          wreg_o  = 1'b0;
          wdata_o = 32'h0;
          if (flush_i) begin
            next_state = MEM_IDLE;
          end else if (la_misalign) begin
            err_align_o = 1'b1;
          end else begin
            start      = 1'b1;
            stallreq_o = 1'b1;
            next_state = MEM_BUS;
          end
        end
      end
      MEM_BUS: begin
        wd_o    = op_wd;
        wreg_o  = 1'b0;
        wdata_o = 32'h0;
        if (bus_ack_i) begin
          if (!killed && !bus_we_o) begin
            wreg_o  = wreg_i;
            wdata_o = la_load;
          end
          next_state = (killed || !stall_i[4]) ? MEM_IDLE : MEM_HOLD;
        end else if (timeout) begin
          err_bus_o  = 1'b1;
          next_state = MEM_IDLE;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      MEM_HOLD: begin
        wd_o    = buf_wd;
        wreg_o  = buf_wreg & ~flush_i;
        wdata_o = buf_wdata;
        if (flush_i || !stall_i[4]) begin
          next_state = MEM_IDLE;
        end
      end
      default: begin
        next_state = MEM_IDLE;
      end
    endcase
    if (rst) begin
      next_state  = MEM_IDLE;
      start       = 1'b0;
      wd_o        = NOP_REG_ADDR;
      wreg_o      = 1'b0;
      wdata_o     = 32'h0;
      stallreq_o  = 1'b0;
      err_align_o = 1'b0;
      err_bus_o   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MEM_IDLE;
      bus_addr_o  <= 32'h0;
      bus_wdata_o <= 32'h0;
      bus_sel_o   <= 4'b0000;
      bus_we_o    <= 1'b0;
      bus_stb_o   <= 1'b0;
      op_wd       <= NOP_REG_ADDR;
      op_aluop    <= 8'h00;
      op_off      <= 2'b00;
      op_flushed  <= 1'b0;
      cnt         <= '0;
      buf_wd      <= NOP_REG_ADDR;
      buf_wreg    <= 1'b0;
      buf_wdata   <= 32'h0;
    end else begin
      state <= next_state;
      case (state)
        MEM_IDLE: begin
          if (start) begin
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_wdata_o <= in_is_store ? la_wdata : 32'h0;
            bus_sel_o   <= la_sel;
            bus_we_o    <= in_is_store;
            bus_stb_o   <= 1'b1;
            op_wd       <= wd_i;
            op_aluop    <= aluop_i;
            op_off      <= mem_addr_i[1:0];
            op_flushed  <= 1'b0;
            cnt         <= '0;
          end
        end
        MEM_BUS: begin
          if (bus_ack_i || timeout) begin
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
            bus_sel_o   <= 4'b0000;
            bus_we_o    <= 1'b0;
            bus_stb_o   <= 1'b0;
          end else begin
            if (TIMEOUT_EN) begin
              cnt <= cnt + 1'b1;
            end
            if (flush_i) begin
              op_flushed <= 1'b1;
            end
          end
          // Snapshot exactly what was presented in the ack cycle.
          if (bus_ack_i) begin
            buf_wd    <= op_wd;
            buf_wreg  <= wreg_o;
            buf_wdata <= wdata_o;
          end
        end
        MEM_HOLD: begin
          if (flush_i) begin
            buf_wreg <= 1'b0;
          end
        end
        default: begin
          buf_wreg <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// tb_mem_access : scoreboard bench for mem_access (directed load/store cases)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access;

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;
  localparam logic [7:0] OP_OR  = 8'b00100101;

  localparam logic [1:0] K_XFER  = 2'd0;
  localparam logic [1:0] K_ALIGN = 2'd1;
  localparam logic [1:0] K_BUS   = 2'd2;

  logic        clk;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_we_o;
  logic        bus_stb_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        err_align_o;
  logic        err_bus_o;

  mem_access #(.BUS_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .aluop_i     (aluop_i),
    .mem_addr_i  (mem_addr_i),
    .reg2_i      (reg2_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stallreq_o  (stallreq_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_sel_o   (bus_sel_o),
    .bus_we_o    (bus_we_o),
    .bus_stb_o   (bus_stb_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .err_align_o (err_align_o),
    .err_bus_o   (err_bus_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] bwdata;
    logic        wreg;
    logic [31:0] wdata;
    logic [4:0]  wd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] kind, input logic [31:0] addr,
                              input logic [3:0] sel, input logic we,
                              input logic [31:0] bwdata, input logic wreg,
                              input logic [31:0] wdata);
    exp_t e;
    e.kind = kind; e.addr = addr; e.sel = sel; e.we = we;
    e.bwdata = bwdata; e.wreg = wreg; e.wdata = wdata; e.wd = 5'd9;
    return e;
  endfunction

  task automatic score(input logic [1:0] kind);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d required no event", kind);
    end else begin
      e = sb.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      if (kind == K_XFER && e.kind == K_XFER) begin
        check("xfer_bus", 64'({bus_sel_o, bus_we_o, bus_addr_o}), 64'({e.sel, e.we, e.addr}));
        check("xfer_bwdata", 64'(bus_wdata_o), 64'(e.bwdata));
        check("xfer_wb", 64'({wreg_o, wd_o, wdata_o}), 64'({e.wreg, e.wd, e.wdata}));
      end
    end
  endtask

  // Monitor: every completed transfer or error pulse consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_stb_o && bus_ack_i) score(K_XFER);
      if (err_align_o)            score(K_ALIGN);
      if (err_bus_o)              score(K_BUS);
    end
  end

  task automatic drive_nop();
    aluop_i    = 8'h00;
    wd_i       = 5'd1;
    wreg_i     = 1'b1;
    wdata_i    = 32'hA5A5_0001;
    mem_addr_i = 32'h0;
    reg2_i     = 32'h0;
    flush_i    = 1'b0;
  endtask

  task automatic drive_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] r2, input logic wr);
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = r2;
    wd_i       = 5'd9;
    wreg_i     = wr;
    wdata_i    = addr;
  endtask

  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] r2, input logic [31:0] rdata,
                         input logic wr, input int delay, input int hold,
                         input logic fl, input logic [31:0] hold_exp);
    drive_op(op, addr, r2, wr);
    @(negedge clk);
    check("stallreq_issue", 64'(stallreq_o), 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < delay; i++) begin
      flush_i = fl && (i == 0);
      @(negedge clk);
      check("stb_wait", 64'({bus_stb_o, stallreq_o}), 64'd3);
      @(posedge clk); #1;
    end
    flush_i     = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = rdata;
    stall_i     = (hold > 0) ? 6'b010000 : 6'b000000;
    @(negedge clk);
    check("stallreq_ack", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h5A5A_5A5A;
    if (hold > 0) begin
      for (int i = 0; i <= hold; i++) begin
        if (i == hold) stall_i = 6'b000000;
        @(negedge clk);
        check("hold_data", 64'(wdata_o), 64'(hold_exp));
        check("hold_quiet", 64'({bus_stb_o, stallreq_o}), 64'd0);
        @(posedge clk); #1;
      end
    end
    drive_nop();
    @(negedge clk);
    check("idle_after", 64'({bus_stb_o, stallreq_o, wdata_o}), 64'({2'b00, 32'hA5A5_0001}));
    @(posedge clk); #1;
  endtask

  task automatic run_misalign(input logic [7:0] op, input logic [31:0] addr);
    sb.push_back(mk(K_ALIGN, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0));
    drive_op(op, addr, 32'h1111_2222, 1'b1);
    @(negedge clk);
    check("misalign_quiet", 64'({stallreq_o, wreg_o}), 64'd0);
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    check("misalign_nobus", 64'({bus_stb_o, err_align_o}), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int stb_cnt;
    rst         = 1'b1;
    stall_i     = 6'b000000;
    flush_i     = 1'b0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    drive_op(OP_LW, 32'h101, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_wb", 64'({wd_o, wreg_o, wdata_o, stallreq_o}), 64'd0);
    check("reset_bus", 64'({bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o}), 64'd0);
    check("reset_err", 64'({bus_wdata_o, err_align_o, err_bus_o}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    drive_op(OP_OR, 32'h0, 32'h0, 1'b1);
    wd_i = 5'd3; wdata_i = 32'h1234_5678;
    @(negedge clk);
    check("passthru", 64'({wd_o, wreg_o, wdata_o, stallreq_o}), 64'({5'd3, 1'b1, 32'h1234_5678, 1'b0}));
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(negedge clk);
    check("passthru_flush", 64'({wreg_o, stallreq_o}), 64'd0);
    @(posedge clk); #1;

    drive_op(OP_LW, 32'h100, 32'h0, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    check("idle_flush_nostart", 64'({stallreq_o, wreg_o}), 64'd0);
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    check("idle_flush_nobus", 64'(bus_stb_o), 64'd0);
    @(posedge clk); #1;

    sb.push_back(mk(K_XFER, 32'h100, 4'b1111, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF));
    run_mem(OP_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1, 0, 0, 1'b0, 32'h0);
    sb.push_back(mk(K_XFER, 32'h100, 4'b0001, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF0));
    run_mem(OP_LB, 32'h103, 32'h0, 32'h0000_00F0, 1'b1, 0, 0, 1'b0, 32'h0);
    sb.push_back(mk(K_XFER, 32'h100, 4'b0001, 1'b0, 32'h0, 1'b1, 32'h0000_00F0));
    run_mem(OP_LBU, 32'h103, 32'h0, 32'h0000_00F0, 1'b1, 0, 0, 1'b0, 32'h0);
    sb.push_back(mk(K_XFER, 32'h100, 4'b0011, 1'b1, 32'hABCD_ABCD, 1'b0, 32'h0));
    run_mem(OP_SH, 32'h102, 32'h1234_ABCD, 32'h0, 1'b1, 0, 0, 1'b0, 32'h0);
    sb.push_back(mk(K_XFER, 32'h100, 4'b1100, 1'b0, 32'h0, 1'b1, 32'hFFFF_8001));
    run_mem(OP_LH, 32'h100, 32'h0, 32'h8001_7FFF, 1'b1, 1, 0, 1'b0, 32'h0);
    sb.push_back(mk(K_XFER, 32'h100, 4'b0011, 1'b0, 32'h0, 1'b1, 32'h0000_F00D));
    run_mem(OP_LHU, 32'h102, 32'h0, 32'h8001_F00D, 1'b1, 0, 0, 1'b0, 32'h0);
    sb.push_back(mk(K_XFER, 32'h100, 4'b0100, 1'b1, 32'h5555_5555, 1'b0, 32'h0));
    run_mem(OP_SB, 32'h101, 32'hFFFF_FF55, 32'h0, 1'b0, 0, 0, 1'b0, 32'h0);
    sb.push_back(mk(K_XFER, 32'h104, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0));
    run_mem(OP_SW, 32'h104, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 0, 1'b0, 32'h0);

    run_misalign(OP_LW, 32'h101);
    run_misalign(OP_SH, 32'h103);

    sb.push_back(mk(K_XFER, 32'h108, 4'b1111, 1'b0, 32'h0, 1'b1, 32'h0BAD_C0DE));
    run_mem(OP_LW, 32'h108, 32'h0, 32'h0BAD_C0DE, 1'b1, 3, 2, 1'b0, 32'h0BAD_C0DE);

    sb.push_back(mk(K_XFER, 32'h10C, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0));
    run_mem(OP_LW, 32'h10C, 32'h0, 32'h7777_7777, 1'b1, 2, 0, 1'b1, 32'h0);

    // Transfer that never completes: strobe must drop after the timeout window.
    sb.push_back(mk(K_BUS, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0));
    drive_op(OP_LW, 32'h200, 32'h0, 1'b1);
    @(negedge clk);
    check("to_stallreq_issue", 64'(stallreq_o), 64'd1);
    stb_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus_stb_o) stb_cnt++;
      if (err_bus_o) begin
        check("to_abort_wb", 64'({stallreq_o, wreg_o}), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    check("to_stb_cycles", 64'(stb_cnt), 64'd4);
    check("to_stb_dropped", 64'({bus_stb_o, stallreq_o}), 64'd0);
    @(posedge clk); #1;

    drive_op(OP_LW, 32'h400, 32'h0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_stb_on", 64'(bus_stb_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive_nop();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_stb_off", 64'({bus_stb_o, stallreq_o}), 64'd0);
    @(posedge clk); #1;

    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
